// File: rtl/ecc_secded_pipe.sv
// SECDED (Hamming plus overall parity) encode/check/correct block for FIFO and RAM paths.
//
// Write side: a combinational encoder (wr_data -> wr_parity).
// Read side: decodes the stored word, corrects single-bit errors and flags uncorrectable ones.
// The result sits in one valid/ready output register stage. Saturating counters and a
// first-error syndrome log update on the output handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_data/wr_parity data to encode / its check bits (combinational)
//   rd_valid/rd_ready read word handshake; rd_data/rd_parity stored word; bypass per word
//   out_valid/out_ready output handshake; out_data/out_sbit/out_dbit/out_syndrome result
//   cnt_clr           clears counters and log
//   sbit_cnt/dbit_cnt saturating error counters; log_valid/log_syndrome first-error log
module ecc_secded_pipe #(
  parameter int unsigned DATA_WIDTH   = 37,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [PARITY_WIDTH-1:0] wr_parity,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [PARITY_WIDTH-1:0] rd_parity,
  input  logic                    bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sbit,
  output logic                    out_dbit,
  output logic [PARITY_WIDTH-1:0] out_syndrome,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    log_valid,
  output logic [PARITY_WIDTH-1:0] log_syndrome
);

  typedef logic [PARITY_WIDTH-1:0] col_t;

  // Parameter legality: enough distinct odd-weight columns must exist.
  if (DATA_WIDTH < 4) begin : g_bad_width
    $error("ecc_secded_pipe: DATA_WIDTH must be >= 4");
  end
  if ((64'd1 << (PARITY_WIDTH - 1)) < 64'(DATA_WIDTH + PARITY_WIDTH)) begin : g_bad_parity
    $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
  end

  // Column of data bit idx: the (idx+1)-th non-power-of-two integer >= 3 in the low bits,
  // with the top bit chosen so the column weight is odd.
  function automatic col_t col_of(input int unsigned idx);
    int unsigned n;
    int unsigned v;
    col_t        c;
    n = 0;
    v = 0;
    for (int unsigned k = 3; k < (32'd1 << (PARITY_WIDTH - 1)); k++) begin
      if ((k & (k - 1)) != 0) begin
        if (n == idx) v = k;
        n++;
      end
    end
    c = col_t'(v);
    c[PARITY_WIDTH-1] = ~(^c);
    return c;
  endfunction

  col_t cols [DATA_WIDTH];

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cols
    localparam col_t Col = col_of(unsigned'(i));
    assign cols[i] = Col;
  end

  // Encoders for both the write side and the read-side recomputation.
  col_t rd_calc;

  always_comb begin
    wr_parity = '0;
    rd_calc   = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (wr_data[i]) wr_parity = wr_parity ^ cols[i];
      if (rd_data[i]) rd_calc = rd_calc ^ cols[i];
    end
  end

  // Syndrome decode and correction.
  col_t                  syndrome;
  logic [DATA_WIDTH-1:0] corrected;
  logic                  col_hit;
  logic                  check_err;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_sbit;
  logic                  dec_dbit;

  always_comb begin
    syndrome  = rd_parity ^ rd_calc;
    corrected = rd_data;
    col_hit   = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (syndrome == cols[i]) begin
        corrected[i] = ~rd_data[i];
        col_hit      = 1'b1;
      end
    end
    // A weight-one syndrome points at a flipped check bit; data is already good.
    check_err = $onehot(syndrome);
    dec_data  = corrected;
    dec_sbit  = col_hit | check_err;
    dec_dbit  = (syndrome != '0) & ~(col_hit | check_err);
    if (bypass) begin
      dec_data = rd_data;
      dec_sbit = 1'b0;
      dec_dbit = 1'b0;
    end
  end

  // Output register stage.
  logic rd_accept;
  logic out_fire;

  assign rd_ready  = ~out_valid | out_ready;
  assign rd_accept = rd_valid & rd_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sbit     <= 1'b0;
      out_dbit     <= 1'b0;
      out_syndrome <= '0;
    end else if (rd_accept) begin
      out_valid    <= 1'b1;
      out_data     <= dec_data;
      out_sbit     <= dec_sbit;
      out_dbit     <= dec_dbit;
      out_syndrome <= syndrome;
    end else if (out_fire) begin
      out_valid    <= 1'b0;
    end
  end

  // Counters and first-error log; clear beats a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sbit_cnt     <= '0;
      dbit_cnt     <= '0;
      log_valid    <= 1'b0;
      log_syndrome <= '0;
    end else if (out_fire) begin
      if (out_sbit && (sbit_cnt != '1)) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (out_dbit && (dbit_cnt != '1)) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      if (!log_valid && (out_sbit || out_dbit)) begin
        log_valid    <= 1'b1;
        log_syndrome <= out_syndrome;
      end
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe: a default 37/7 instance, a 2-bit counter instance on
// the same read stream, and a 64/8 instance for single-bit round-trip correction.
module tb_ecc_secded_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_valid, bypass, out_ready, cnt_clr;
  logic [36:0] wr_data, rd_data;
  logic [6:0]  rd_parity;

  logic [6:0]  wr_parity, out_syndrome, log_syndrome;
  logic        rd_ready, out_valid, out_sbit, out_dbit, log_valid;
  logic [36:0] out_data;
  logic [15:0] sbit_cnt, dbit_cnt;

  logic [6:0]  wr_parity_s, out_syndrome_s, log_syndrome_s;
  logic        rd_ready_s, out_valid_s, out_sbit_s, out_dbit_s, log_valid_s;
  logic [36:0] out_data_s;
  logic [1:0]  sbit_cnt_s, dbit_cnt_s;

  logic [63:0] wr_data_w, rd_data_w, out_data_w;
  logic [7:0]  rd_parity_w, wr_parity_w, out_syndrome_w, log_syndrome_w;
  logic        rd_ready_w, out_valid_w, out_sbit_w, out_dbit_w, log_valid_w;
  logic [15:0] sbit_cnt_w, dbit_cnt_w;

  ecc_secded_pipe u_dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_parity(wr_parity),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_parity(rd_parity),
    .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sbit(out_sbit), .out_dbit(out_dbit), .out_syndrome(out_syndrome),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .log_valid(log_valid), .log_syndrome(log_syndrome)
  );

  ecc_secded_pipe #(.DATA_WIDTH(37), .PARITY_WIDTH(7), .CNT_WIDTH(2)) u_dut_s (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_parity(wr_parity_s),
    .rd_valid(rd_valid), .rd_ready(rd_ready_s), .rd_data(rd_data), .rd_parity(rd_parity),
    .bypass(bypass), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_sbit(out_sbit_s), .out_dbit(out_dbit_s), .out_syndrome(out_syndrome_s),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt_s), .dbit_cnt(dbit_cnt_s),
    .log_valid(log_valid_s), .log_syndrome(log_syndrome_s)
  );

  ecc_secded_pipe #(.DATA_WIDTH(64), .PARITY_WIDTH(8), .CNT_WIDTH(16)) u_dut_w (
    .clk(clk), .rst(rst), .wr_data(wr_data_w), .wr_parity(wr_parity_w),
    .rd_valid(rd_valid), .rd_ready(rd_ready_w), .rd_data(rd_data_w), .rd_parity(rd_parity_w),
    .bypass(bypass), .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_sbit(out_sbit_w), .out_dbit(out_dbit_w), .out_syndrome(out_syndrome_w),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt_w), .dbit_cnt(dbit_cnt_w),
    .log_valid(log_valid_w), .log_syndrome(log_syndrome_w)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge; returns at the next negedge with the word registered.
  task automatic xfer(input logic [36:0] d, input logic [6:0] p, input logic b);
    rd_data   = d;
    rd_parity = p;
    bypass    = b;
    rd_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rd_valid  = 1'b0;
    bypass    = 1'b0;
  endtask

  task automatic xfer_w(input logic [63:0] d, input logic [7:0] p);
    rd_data_w   = d;
    rd_parity_w = p;
    rd_valid    = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    rd_valid    = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [36:0] d, input logic [6:0] syn,
                           input logic sb, input logic db);
    check_eq({tag, ".valid"}, out_valid, 1'b1);
    check_eq({tag, ".data"}, out_data, d);
    check_eq({tag, ".syn"}, out_syndrome, syn);
    check_eq({tag, ".sbit"}, out_sbit, sb);
    check_eq({tag, ".dbit"}, out_dbit, db);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] word;
    logic [7:0]  par;
    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_parity = '0; bypass = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0; wr_data = '0;
    wr_data_w = '0; rd_data_w = '0; rd_parity_w = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check_eq("rst.out_valid", out_valid, 1'b0);
    check_eq("rst.out_data", out_data, 0);
    check_eq("rst.rd_ready", rd_ready, 1'b1);
    check_eq("rst.sbit_cnt", sbit_cnt, 0);
    check_eq("rst.dbit_cnt", dbit_cnt, 0);
    check_eq("rst.log_valid", log_valid, 1'b0);
    check_eq("rst.log_syn", log_syndrome, 0);

    // Encoder vectors from the column table (d0=43h, d1=45h, d2=46h, d3=07h, d7=4Ch, d36=6Bh).
    wr_data = 37'h0;         #1 check_eq("enc.zero", wr_parity, 7'h00);
    wr_data = 37'h1;         #1 check_eq("enc.d0", wr_parity, 7'h43);
    wr_data = 37'h3;         #1 check_eq("enc.d0d1", wr_parity, 7'h06);
    wr_data = 37'hF;         #1 check_eq("enc.nib", wr_parity, 7'h47);
    wr_data = 37'h80;        #1 check_eq("enc.d7", wr_parity, 7'h4C);
    wr_data = 37'h1_0000_0000 << 4; #1 check_eq("enc.d36", wr_parity, 7'h6B);
    wr_data_w = 64'h1;       #1 check_eq("encw.d0", wr_parity_w, 8'h83);
    wr_data_w = 64'h1 << 63; #1 check_eq("encw.d63", wr_parity_w, 8'hC7);
    @(negedge clk);

    xfer(37'h0, 7'h00, 1'b0);  check_out("clean0", 37'h0, 7'h00, 1'b0, 1'b0);
    step();
    check_eq("clean0.drain", out_valid, 1'b0);

    xfer(37'h1, 7'h00, 1'b0);  check_out("d0flip", 37'h0, 7'h43, 1'b1, 1'b0);
    step();
    check_eq("d0flip.scnt", sbit_cnt, 1);
    check_eq("d0flip.logv", log_valid, 1'b1);
    check_eq("d0flip.logs", log_syndrome, 7'h43);

    xfer(37'h0, 7'h01, 1'b0);  check_out("p0flip", 37'h0, 7'h01, 1'b1, 1'b0);
    step();
    check_eq("p0flip.scnt", sbit_cnt, 2);

    xfer(37'h3, 7'h00, 1'b0);  check_out("dbl", 37'h3, 7'h06, 1'b0, 1'b1);
    step();
    check_eq("dbl.dcnt", dbit_cnt, 1);
    check_eq("dbl.scnt", sbit_cnt, 2);
    check_eq("dbl.logs", log_syndrome, 7'h43);

    xfer(37'h1, 7'h00, 1'b1);  check_out("byp", 37'h1, 7'h43, 1'b0, 1'b0);
    step();
    check_eq("byp.scnt", sbit_cnt, 2);
    check_eq("byp.dcnt", dbit_cnt, 1);

    xfer(37'h1_0000_0000 << 4, 7'h00, 1'b0);
    check_out("d36flip", 37'h0, 7'h6B, 1'b1, 1'b0);
    step();
    check_eq("d36flip.scnt", sbit_cnt, 3);

    xfer(37'hF, 7'h47, 1'b0);  check_out("cleanF", 37'hF, 7'h00, 1'b0, 1'b0);
    step();
    xfer(37'h8F, 7'h47, 1'b0); check_out("d7flip", 37'hF, 7'h4C, 1'b1, 1'b0);
    step();
    check_eq("d7flip.scnt", sbit_cnt, 4);

    // Odd weight but beyond the last used column: uncorrectable.
    xfer(37'h0, 7'h7F, 1'b0);  check_out("oddnc", 37'h0, 7'h7F, 1'b0, 1'b1);
    step();
    check_eq("oddnc.dcnt", dbit_cnt, 2);

    // Stall: word A held while B waits on the input.
    rd_data = 37'h1; rd_parity = 7'h00; rd_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check_eq("stall.rdy", rd_ready, 1'b0);
    rd_data = 37'hF; rd_parity = 7'h47;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out("stall.hold", 37'h0, 7'h43, 1'b1, 1'b0);
      check_eq("stall.rdy", rd_ready, 1'b0);
      check_eq("stall.scnt", sbit_cnt, 4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("stall.B", 37'hF, 7'h00, 1'b0, 1'b0);
    check_eq("stall.scnt1", sbit_cnt, 5);
    rd_valid = 1'b0;
    @(negedge clk);
    check_eq("stall.scnt2", sbit_cnt, 5);
    check_eq("stall.drain", out_valid, 1'b0);

    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check_eq("clr.scnt", sbit_cnt, 0);
    check_eq("clr.dcnt", dbit_cnt, 0);
    check_eq("clr.logv", log_valid, 1'b0);
    check_eq("clr.logs", log_syndrome, 0);

    // Reset while a word is stalled in the output register.
    rd_data = 37'h1; rd_parity = 7'h00; rd_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rd_valid = 1'b0;
    check_eq("mrst.pre", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst.valid", out_valid, 1'b0);
    check_eq("mrst.data", out_data, 0);
    check_eq("mrst.syn", out_syndrome, 0);
    check_eq("mrst.sbit", out_sbit, 1'b0);
    check_eq("mrst.rdy", rd_ready, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("mrst.scnt", sbit_cnt, 0);

    // Saturation with the 2-bit counters.
    for (int k = 1; k <= 5; k++) begin
      xfer(37'h1, 7'h00, 1'b0);
      step();
      check_eq("sat.scnt_s", sbit_cnt_s, (k > 3) ? 3 : k);
    end
    check_eq("sat.scnt", sbit_cnt, 5);
    xfer(37'h1, 7'h00, 1'b0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check_eq("satclr.scnt_s", sbit_cnt_s, 0);
    check_eq("satclr.logv_s", log_valid_s, 1'b0);
    check_eq("satclr.scnt", sbit_cnt, 0);
    check_eq("satclr.logv", log_valid, 1'b0);
    xfer(37'h0, 7'h01, 1'b0);
    step();
    check_eq("rearm.scnt_s", sbit_cnt_s, 1);
    check_eq("rearm.logs_s", log_syndrome_s, 7'h01);

    // 64/8 round trip: every single data-bit and check-bit flip must be corrected.
    for (int n = 0; n < 3; n++) begin
      word = (n == 0) ? 64'h0123_4567_89AB_CDEF : {$urandom(), $urandom()};
      wr_data_w = word;
      #1 par = wr_parity_w;
      for (int k = 0; k < 64; k++) begin
        xfer_w(word ^ (64'h1 << k), par);
        check_eq("rt.data", out_data_w, word);
        check_eq("rt.sbit", out_sbit_w, 1'b1);
        check_eq("rt.dbit", out_dbit_w, 1'b0);
      end
      for (int j = 0; j < 8; j++) begin
        xfer_w(word, par ^ (8'h1 << j));
        check_eq("rtp.data", out_data_w, word);
        check_eq("rtp.sbit", out_sbit_w, 1'b1);
      end
      xfer_w(word, par);
      check_eq("rtc.data", out_data_w, word);
      check_eq("rtc.syn", out_syndrome_w, 0);
      xfer_w(word ^ 64'h3, par);
      check_eq("rtd.dbit", out_dbit_w, 1'b1);
      check_eq("rtd.data", out_data_w, word ^ 64'h3);
    end
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
Parametrised SECDED (Hamming plus overall-parity) encode/check/correct block for FIFO and RAM data paths. It generalises the fixed 37-bit combinational calculator to any data width. It adds:
- a registered, valid/ready-handshaked decode stage;
- saturating single-bit and double-bit error counters;
- a first-error syndrome log.

The write side uses the combinational encoder. The read side sits between the memory read port and the consumer.

Parameters:
DATA_WIDTH, 37, data bits per word (>=4).
PARITY_WIDTH, 7, check bits; must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH (elaboration error otherwise).
CNT_WIDTH, 16, width of each error counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
wr_data  in  DATA_WIDTH  data to encode.
wr_parity  out  PARITY_WIDTH  check bits for wr_data (combinational, no latency).
rd_valid  in  1  read word valid.
rd_ready  out  1  block can accept read word.
rd_data  in  DATA_WIDTH  stored data.
rd_parity  in  PARITY_WIDTH  stored check bits.
bypass  in  1  sampled with the word; disables correction and error flags for that word.
out_valid  out  1  corrected word valid.
out_ready  in  1  consumer accepts.
out_data  out  DATA_WIDTH  corrected (or raw if bypassed) data.
out_sbit  out  1  single-bit error detected/corrected on this word.
out_dbit  out  1  uncorrectable error on this word.
out_syndrome  out  PARITY_WIDTH  syndrome of this word.
cnt_clr  in  1  clear counters and log.
sbit_cnt  out  CNT_WIDTH  saturating count of accepted words with out_sbit.
dbit_cnt  out  CNT_WIDTH  saturating count of accepted words with out_dbit.
log_valid  out  1  first-error log holds an entry.
log_syndrome  out  PARITY_WIDTH  syndrome of first error since clear.

Behaviour:
Code construction:
- Data bit i column: low PARITY_WIDTH-1 bits = the (i+1)-th integer >=3 that is not a power of two, in ascending order (d0=3, d1=5, d2=6, d3=7, d4=9, ...).
- Top bit is set when needed to make the column weight odd. Example: d0=1000011, d3=0000111.
- Check bit j column is the unit vector e_j.
- parity[j] = XOR of data bits whose column has bit j set.

Syndrome decode: syndrome = rd_parity ^ encode(rd_data).
- Zero: clean; sbit=0, dbit=0.
- Equals a data column: flip that data bit; sbit=1.
- Weight 1 (check-bit error): data unchanged; sbit=1.
- Any other non-zero value (even weight, or odd weight with no matching column): data unchanged; dbit=1.
- When the sampled bypass=1: out_data=rd_data, sbit=dbit=0; out_syndrome is still reported.

Handshake and pipeline:
- One output register stage; latency 1 cycle from rd accept to out_valid.
- rd_ready = ~out_valid | out_ready.
- Accept occurs when rd_valid & rd_ready; decoded results load into the output register on that clk edge.
- out_valid is set on accept. It clears on out_valid & out_ready with no new accept.
- Back-to-back accepts give full throughput.
- While out_valid & ~out_ready, all out_* outputs hold stable.

Counters and log:
- Counters and log update on the output handshake (out_valid & out_ready), never on a stall.
- sbit_cnt / dbit_cnt increment by 1 and saturate at 2^CNT_WIDTH-1.
- log_valid sets on the first handshaked word with sbit|dbit, and log_syndrome captures its syndrome. Later errors do not overwrite the log until cnt_clr.
- cnt_clr zeroes both counters, log_valid and log_syndrome. It wins over a same-cycle increment or capture; that word is not counted.

Reset:
- out_valid=0, out_data=0, out_sbit=0, out_dbit=0, out_syndrome=0, counters=0, log_valid=0, log_syndrome=0.
- rd_ready=1 the cycle after reset.
- Reset mid-transfer discards the held word with no counter update.
- wr_parity is purely combinational and unaffected by rst.

Test Plan:
- Defaults, rst then rd_data=0, rd_parity=0, out_ready=1 -> next cycle out_valid=1, out_data=0, out_syndrome=0, sbit=dbit=0; wr_data=0 gives wr_parity=0.
- rd_data=0x000000001, rd_parity=0 -> out_syndrome=7'b1000011, out_data=0, out_sbit=1, sbit_cnt=1, log_valid=1, log_syndrome=1000011.
- rd_data=0, rd_parity=7'b0000001 -> out_data=0, out_sbit=1; rd_data=0x3 (d0,d1), rd_parity=0 -> syndrome 0000110, out_dbit=1, out_data=0x3, dbit_cnt=1, log unchanged.
- Same single-bit word with bypass=1 -> out_data=0x000000001, sbit=dbit=0, counters unchanged.
- Hold out_ready=0 for 5 cycles with rd_valid=1 -> rd_ready=0 from cycle 2; outputs stable; counter increments once only after out_ready=1.
- CNT_WIDTH=2, 5 single-bit words -> sbit_cnt saturates at 3; cnt_clr together with a 6th error handshake -> sbit_cnt=0, log_valid=0; re-run with DATA_WIDTH=64, PARITY_WIDTH=8: random data encode/decode round-trip corrects every single-bit flip.
